led_fader: RTL and testbench



---
 rtl/led_fader_pkg.sv | 25 ++
 rtl/pwm_channel.sv | 36 +++
 rtl/led_fader.sv | 99 +++++++++
 tb/tb_led_fader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_fader_pkg.sv
// Shared types and helpers for the LED fader: FSM state encoding and the
// saturating brightness step used by every PWM channel.
package led_fader_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } fade_state_t;

  // One extra bit of headroom so neither direction can wrap before clamping.
  function automatic logic [31:0] sat_step(input logic [31:0] level,
                                           input logic [31:0] step,
                                           input logic        up,
                                           input logic [31:0] level_max);
    logic [32:0] wide;
    if (up) begin
      wide = {1'b0, level} + {1'b0, step};
      return (wide > {1'b0, level_max}) ? level_max : wide[31:0];
    end else begin
      wide = {1'b0, level} - {1'b0, step};
      return wide[32] ? 32'd0 : wide[31:0];
    end
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One LED channel: brightness level that ramps toward a 1-bit goal on each
// enabled tick, plus the registered PWM compare that drives the pin.
module pwm_channel
  import led_fader_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int STEP     = 1
) (
  input  logic                clock_12mhz,
  input  logic                reset,
  input  logic                step_en,
  input  logic                goal,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic [PWM_BITS-1:0] level,
  output logic                led,
  output logic                settled
);

  localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;

  always_ff @(posedge clock_12mhz or posedge reset) begin
    if (reset) begin
      level <= '0;
      led   <= 1'b0;
    end else begin
      if (step_en) begin
        level <= PWM_BITS'(sat_step(32'(level), 32'(STEP), goal, 32'(LEVEL_MAX)));
      end
      // Full scale is forced high so the top level never shows a one-clock gap.
      led <= (level == LEVEL_MAX) || (pwm_cnt < level);
    end
  end

  assign settled = goal ? (level == LEVEL_MAX) : (level == '0);

endmodule

// File: rtl/led_fader.sv
// LED fader top: accepts an on/off target over valid/ready and ramps each
// LED's PWM brightness toward it at a fixed tick rate.
module led_fader
  import led_fader_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int PWM_BITS = 8,
  parameter int TICK_DIV = 12000,
  parameter int STEP     = 1
) (
  input  logic                clock_12mhz,
  input  logic                reset,
  input  logic [CHANNELS-1:0] target,
  input  logic                target_valid,
  output logic                ready,
  output logic                busy,
  output logic [CHANNELS-1:0] led
);

  // Handshake: a target transfers on a rising edge where target_valid and
  // ready are both high; the source holds target stable until then.

  localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [PRESC_W-1:0]  presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;
  logic                step_en;
  logic                all_settled;
  logic [CHANNELS-1:0] goal;
  logic [CHANNELS-1:0] settled;
  fade_state_t         state;

  assign tick        = (presc == PRESC_W'(TICK_DIV - 1));
  assign step_en     = (state == FADE) && tick;
  assign all_settled = &settled;

  always_ff @(posedge clock_12mhz or posedge reset) begin
    if (reset) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else begin
      presc   <= tick ? '0 : presc + PRESC_W'(1);
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  always_ff @(posedge clock_12mhz or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      goal  <= '0;
      ready <= 1'b1;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (target_valid) begin
            goal  <= target;
            state <= FADE;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        FADE: begin
          // Checked every cycle so a no-op target leaves after one cycle.
          if (all_settled) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : gen_ch
    logic [PWM_BITS-1:0] level;

    pwm_channel #(
      .PWM_BITS(PWM_BITS),
      .STEP    (STEP)
    ) u_ch (
      .clock_12mhz(clock_12mhz),
      .reset      (reset),
      .step_en    (step_en),
      .goal       (goal[i]),
      .pwm_cnt    (pwm_cnt),
      .level      (level),
      .led        (led[i]),
      .settled    (settled[i])
    );
  end

endmodule

// File: tb/tb_led_fader.sv
// Bench for led_fader: table of fade targets checked through a per-tick
// level scoreboard, plus duty, backpressure and reset-mid-fade sequences.
module tb_led_fader;

  logic       clock_12mhz = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] target = '0;
  logic       target_valid = 1'b0;
  logic       ready, busy;
  logic [7:0] led;
  logic [7:0] target2 = '0;
  logic       target_valid2 = 1'b0;
  logic       ready2, busy2;
  logic [7:0] led2;

  always #5 clock_12mhz = ~clock_12mhz;

  led_fader #(.CHANNELS(8), .PWM_BITS(8), .TICK_DIV(4), .STEP(64)) dut (
    .clock_12mhz (clock_12mhz),
    .reset       (reset),
    .target      (target),
    .target_valid(target_valid),
    .ready       (ready),
    .busy        (busy),
    .led         (led)
  );

  led_fader #(.CHANNELS(8), .PWM_BITS(8), .TICK_DIV(1024), .STEP(128)) dut2 (
    .clock_12mhz (clock_12mhz),
    .reset       (reset),
    .target      (target2),
    .target_valid(target_valid2),
    .ready       (ready2),
    .busy        (busy2),
    .led         (led2)
  );

  // Rising edges since the last reset release; dut ticks on edges that are multiples of 4.
  int cyc;
  always @(posedge clock_12mhz or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  logic [63:0] exp_q[$];
  logic [7:0]  mlev[8];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          pops = 0;
  int          last_pop_cyc = 0;
  int          hs_cyc = 0;
  int          ready_cyc = 0;
  logic        prev_busy = 1'b0;

  typedef struct {
    logic [7:0] t;
    int         ticks;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] dut_levels();
    return {dut.gen_ch[7].level, dut.gen_ch[6].level, dut.gen_ch[5].level,
            dut.gen_ch[4].level, dut.gen_ch[3].level, dut.gen_ch[2].level,
            dut.gen_ch[1].level, dut.gen_ch[0].level};
  endfunction

  // Scoreboard: each tick edge taken while busy pops one expected level vector.
  always @(negedge clock_12mhz) begin
    if (!reset && prev_busy && cyc > 0 && (cyc % 4) == 0 && exp_q.size() > 0) begin
      logic [63:0] e;
      e = exp_q.pop_front();
      check("tick_level", dut_levels(), e);
      pops++;
      last_pop_cyc = cyc;
    end
    prev_busy = busy;
  end

  task automatic send(input logic [7:0] t);
    int g;
    logic done;
    logic [63:0] p;
    for (int s = 0; s < 16; s++) begin
      done = 1'b1;
      for (int i = 0; i < 8; i++)
        if (mlev[i] != (t[i] ? 8'hFF : 8'h00)) done = 1'b0;
      if (done) break;
      for (int i = 0; i < 8; i++) begin
        int v;
        v = t[i] ? int'(mlev[i]) + 64 : int'(mlev[i]) - 64;
        if (v > 255) v = 255;
        if (v < 0) v = 0;
        mlev[i] = 8'(v);
        p[i*8 +: 8] = mlev[i];
      end
      exp_q.push_back(p);
    end
    target = t;
    target_valid = 1'b1;
    g = 0;
    while (ready !== 1'b1 && g < 200) begin
      @(negedge clock_12mhz); #1;
      g++;
    end
    if (g >= 200) check("ready_timeout", 64'(ready), 64'd1);
    ready_cyc = cyc;
    @(posedge clock_12mhz);
    @(negedge clock_12mhz); #1;
    target_valid = 1'b0;
    hs_cyc = cyc;
    check("hs_ready_busy", {62'd0, ready, busy}, 64'd1);
  endtask

  task automatic wait_idle(input logic [7:0] t, input int ticks);
    int g;
    int bad;
    g = 0;
    while (ready !== 1'b1 && g < 200) begin
      @(negedge clock_12mhz); #1;
      g++;
    end
    check("idle_reached", 64'(ready), 64'd1);
    check("tick_count", 64'(pops), 64'(ticks));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    if (ticks == 0) check("noop_one_cycle", 64'(cyc), 64'(hs_cyc + 1));
    else            check("ready_after_last", 64'(cyc), 64'(last_pop_cyc + 1));
    bad = 0;
    for (int k = 0; k < 260; k++) begin
      @(negedge clock_12mhz); #1;
      if (led !== t) bad++;
    end
    check("led_hold", 64'(bad), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int hi, align_bad, other_bad, zero_bad, g;

    vecs[0] = '{8'hFF, 4};
    vecs[1] = '{8'hA5, 4};
    vecs[2] = '{8'hA5, 0};
    vecs[3] = '{8'h5A, 4};
    vecs[4] = '{8'h00, 4};
    vecs[5] = '{8'h3C, 4};
    vecs[6] = '{8'hC3, 4};
    vecs[7] = '{8'h00, 4};
    for (int i = 0; i < 8; i++) mlev[i] = 8'h00;

    #23;
    check("reset_led", 64'(led), 64'd0);
    check("reset_ready_busy", {62'd0, ready, busy}, 64'd2);
    @(negedge clock_12mhz); #1;
    reset = 1'b0;

    // Duty check on dut2: level 128 held between its ticks at edges 1024 and 2048.
    target2 = 8'h01;
    target_valid2 = 1'b1;
    @(posedge clock_12mhz);
    @(negedge clock_12mhz); #1;
    target_valid2 = 1'b0;
    check("dut2_busy", 64'(busy2), 64'd1);
    while (cyc < 1100) begin
      @(negedge clock_12mhz); #1;
    end
    check("dut2_level128", 64'(dut2.gen_ch[0].level), 64'd128);
    hi = 0; align_bad = 0; other_bad = 0; zero_bad = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clock_12mhz); #1;
      if (led2[0] === 1'b1) hi++;
      if (led2[0] !== (((cyc - 1) % 256) < 128)) align_bad++;
      if (led2[7:1] !== 7'd0) other_bad++;
      if (led !== 8'h00) zero_bad++;
    end
    check("duty_high_count", 64'(hi), 64'd128);
    check("duty_alignment", 64'(align_bad), 64'd0);
    check("duty_other_ch", 64'(other_bad), 64'd0);
    check("idle_led_zero", 64'(zero_bad), 64'd0);

    for (int v = 0; v < 8; v++) begin
      pops = 0;
      send(vecs[v].t);
      wait_idle(vecs[v].t, vecs[v].ticks);
    end

    // Backpressure: 0x00 presented during an up-fade waits for ready.
    pops = 0;
    send(8'hFF);
    send(8'h00);
    check("bp_first_fade_ticks", 64'(pops), 64'd4);
    check("bp_ready_timing", 64'(ready_cyc), 64'(last_pop_cyc + 1));
    pops = 0;
    wait_idle(8'h00, 4);

    // Reset in the middle of an up-fade at level 128.
    pops = 0;
    send(8'hFF);
    g = 0;
    while (pops < 2 && g < 50) begin
      @(negedge clock_12mhz); #1;
      g++;
    end
    check("mid_level128", dut_levels(), 64'h8080_8080_8080_8080);
    #1;
    reset = 1'b1;
    #1;
    check("async_led", 64'(led), 64'd0);
    check("async_ready_busy", {62'd0, ready, busy}, 64'd2);
    check("async_levels", dut_levels(), 64'd0);
    exp_q.delete();
    for (int i = 0; i < 8; i++) mlev[i] = 8'h00;
    @(negedge clock_12mhz); #1;
    reset = 1'b0;
    zero_bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock_12mhz); #1;
      if (led !== 8'h00 || ready !== 1'b1) zero_bad++;
    end
    check("post_reset_idle", 64'(zero_bad), 64'd0);
    pops = 0;
    send(8'hFF);
    wait_idle(8'hFF, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
